fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Small first-word-fall-through instruction FIFO between the iCache fetch stage and the decode stage.
- Lets fetch keep streaming (pc+4) while decode is held by a dCache memory stall.
- Flushed on a taken branch/jump resolved in the ALU stage.
- Presents a NOP to decode whenever it holds no valid instruction.

Parameters:
- ARCH_BITS, 32, width of PC and instruction words
- DEPTH, 4, number of entries; must be a power of 2, minimum 2
- PTR_BITS, 2, log2(DEPTH)
- NOP_INSTRUCTION, 32'hFFFFFFFF, encoding presented when no valid entry
- PC_INVALID, 32'hFFFFFFFF, PC presented with a NOP

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  taken branch/jump this cycle (takeBranch)
- enq_valid  in  1  iCache hit, instruction valid (instFetchValid)
- enq_pc  in  ARCH_BITS  PC of fetched instruction
- enq_inst  in  ARCH_BITS  fetched instruction
- enq_ready  out  1  queue can accept; fetch advances pc only when enq_valid && enq_ready
- deq_ready  in  1  decode consumes head this cycle (= !stallDecodeToALU)
- deq_valid  out  1  head entry valid
- deq_pc  out  ARCH_BITS  head PC, PC_INVALID when !deq_valid
- deq_inst  out  ARCH_BITS  head instruction, NOP_INSTRUCTION when !deq_valid
- count  out  PTR_BITS+1  occupancy, 0..DEPTH

Behaviour:
- State: head_ptr and tail_ptr (PTR_BITS each), count (PTR_BITS+1), and a DEPTH x (2*ARCH_BITS) storage array.
- Storage is not reset.
- Reset (async, any time incl. mid-operation): head_ptr=0, tail_ptr=0, count=0.
  - Outputs immediately become deq_valid=0, deq_inst=NOP_INSTRUCTION, deq_pc=PC_INVALID, enq_ready=1, count=0.
- enq_ready = (count != DEPTH). This is purely state-based, so there is no combinational path from deq_ready to enq_ready.
- enq_fire = enq_valid && enq_ready && !flush.
  - Writes {enq_pc, enq_inst} at tail_ptr.
  - tail_ptr <= tail_ptr+1 (wraps modulo DEPTH naturally).
- deq_valid = (count != 0) && !flush.
- deq_pc and deq_inst are read combinationally from the head entry, forced to PC_INVALID / NOP_INSTRUCTION when !deq_valid.
- deq_fire = deq_valid && deq_ready; head_ptr <= head_ptr+1 (wraps).
- Count update:
  - enq_fire only: +1
  - deq_fire only: -1
  - both fire: unchanged (legal when 0<count<DEPTH, also at count==DEPTH-1)
  - neither fires: unchanged
- Latency: no empty-bypass. An instruction enqueued at edge N is first visible on deq at cycle N+1 (1-cycle fetch-to-decode, same as the existing pipeline register).
- Full (count==DEPTH): enq_ready=0, and an enq_valid is ignored even if deq_fire occurs that cycle. Fetch must hold pc.
- Empty (count==0): deq_valid=0 and NOP is presented; deq_ready is ignored.
- Flush has highest priority:
  - Next edge sets head_ptr=0, tail_ptr=0, count=0.
  - Any same-cycle enqueue is discarded.
  - No deq_fire occurs; decode sees a NOP this cycle.
- Flush together with deq_ready=0 (stall) still flushes. Upstream guarantees flush is not asserted during a dCache stall, but the block does not rely on it.
- Pointer arithmetic is done at PTR_BITS width so wrap is implicit. count is PTR_BITS+1 bits so full and empty are distinct.
- Order: strict FIFO. No reordering, no duplicate delivery.

Decomposition:
- Shared package proc_pkg: ARCH_BITS, NOP_INSTRUCTION, PC_INVALID, PC_RST, opcode constants.
- Shared package typedef: fq_entry_t = {pc[ARCH_BITS-1:0], inst[ARCH_BITS-1:0]}.
- No sub-module. Storage is a single register array inside the block. Pointer and count logic is simple enough to stay inline.

Test Plan:
1. Reset mid-stream (count=3), rst pulsed asynchronously between edges -> outputs go to count=0, deq_valid=0, deq_inst=32'hFFFFFFFF, deq_pc=32'hFFFFFFFF, enq_ready=1 without waiting for an edge.
2. Enqueue pc=0x1000,0x1004,0x1008,0x100C with deq_ready=0 -> count reaches 4 and enq_ready=0. A fifth enq (0x1010) is ignored. Then deq_ready=1 for 4 cycles -> outputs 0x1000..0x100C in order, then NOP, count=0.
3. Continuous enq and deq (deq_ready=1) from empty, inst=0xA0..0xA7 -> each inst appears exactly one cycle after its enqueue. count stays at 1 after the first cycle. Pointers wrap twice with no loss.
4. count=2 (0x2000,0x2004), flush=1 with enq_valid=1 (pc 0x2008) and deq_ready=1 -> deq_valid=0 and deq_inst=NOP in that cycle. Next cycle count=0, and 0x2008 is never delivered.
5. count=4, deq_ready=1 and enq_valid=1 in the same cycle -> head is dequeued, enq is rejected (enq_ready=0), count=3. Next cycle enq_ready=1 and the retried enq is accepted.
6. count=0, enq_valid=1 with pc=0x3000 and deq_ready=1 -> deq_valid=0 in that cycle (no bypass). The next cycle shows pc 0x3000 with deq_valid=1.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared processor constants and the fetch-queue entry type.
package fetch_queue_pkg;
    localparam int ARCH_BITS   = 32;
    localparam int FQ_DEPTH    = 4;
    localparam int FQ_PTR_BITS = 2;

    localparam logic [ARCH_BITS-1:0] NOP_INSTRUCTION = 32'hFFFF_FFFF;
    localparam logic [ARCH_BITS-1:0] PC_INVALID      = 32'hFFFF_FFFF;
    localparam logic [ARCH_BITS-1:0] PC_RST          = 32'h0000_0000;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    typedef struct packed {
        logic [ARCH_BITS-1:0] pc;
        logic [ARCH_BITS-1:0] inst;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle; slave side is the queue itself.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int PTR_BITS = FQ_PTR_BITS
);
    logic                 flush;
    logic                 enq_valid;
    logic [ARCH_BITS-1:0] enq_pc;
    logic [ARCH_BITS-1:0] enq_inst;
    logic                 enq_ready;
    logic                 deq_ready;
    logic                 deq_valid;
    logic [ARCH_BITS-1:0] deq_pc;
    logic [ARCH_BITS-1:0] deq_inst;
    logic [PTR_BITS:0]    count;

    modport master (
        output flush, enq_valid, enq_pc, enq_inst, deq_ready,
        input  enq_ready, deq_valid, deq_pc, deq_inst, count
    );

    modport slave (
        input  flush, enq_valid, enq_pc, enq_inst, deq_ready,
        output enq_ready, deq_valid, deq_pc, deq_inst, count
    );
endinterface

// File: rtl/fetch_queue.sv
// First-word-fall-through instruction FIFO between iCache fetch and decode.
// Flush discards everything, including a same-cycle enqueue; empty presents a NOP.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH    = FQ_DEPTH,
    parameter int PTR_BITS = FQ_PTR_BITS
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.slave fq
);
    localparam logic [PTR_BITS:0] FULL = (PTR_BITS+1)'(DEPTH);

    fq_entry_t             mem [DEPTH];
    logic [PTR_BITS-1:0]   head_ptr;
    logic [PTR_BITS-1:0]   tail_ptr;
    logic [PTR_BITS:0]     cnt;
    logic                  enq_fire;
    logic                  deq_fire;
    fq_entry_t             head;

    // enq_ready depends only on state, never on deq_ready.
    assign fq.enq_ready = (cnt != FULL);
    assign fq.deq_valid = (cnt != '0) && !fq.flush;
    assign fq.count     = cnt;
    assign enq_fire     = fq.enq_valid && fq.enq_ready && !fq.flush;
    assign deq_fire     = fq.deq_valid && fq.deq_ready;
    assign head         = mem[head_ptr];

    always_comb begin
        fq.deq_pc   = PC_INVALID;
        fq.deq_inst = NOP_INSTRUCTION;
        if (fq.deq_valid) begin
            fq.deq_pc   = head.pc;
            fq.deq_inst = head.inst;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire)
            mem[tail_ptr] <= '{pc: fq.enq_pc, inst: fq.enq_inst};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            cnt      <= '0;
        end else if (fq.flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            cnt      <= '0;
        end else begin
            if (enq_fire) tail_ptr <= tail_ptr + 1'b1;
            if (deq_fire) head_ptr <= head_ptr + 1'b1;
            unique case ({enq_fire, deq_fire})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus random stimulus for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    fq_entry_t model_q[$];

    fetch_queue_if fif ();

    fetch_queue dut (
        .clk (clk),
        .rst (rst),
        .fq  (fif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input logic fl);
        logic exp_v;
        exp_v = (model_q.size() != 0) && !fl;
        chk("deq_valid", {31'b0, fif.deq_valid}, {31'b0, exp_v});
        chk("deq_pc", fif.deq_pc, exp_v ? model_q[0].pc : PC_INVALID);
        chk("deq_inst", fif.deq_inst, exp_v ? model_q[0].inst : NOP_INSTRUCTION);
        chk("enq_ready", {31'b0, fif.enq_ready}, {31'b0, model_q.size() != FQ_DEPTH});
        chk("count", 32'(fif.count), 32'(model_q.size()));
    endtask

    // Called at a negedge; drives one cycle, checks, and returns at the next negedge.
    task automatic step(input logic fl, input logic ev, input logic [31:0] pc,
                        input logic [31:0] inst, input logic dr);
        bit enq_ok;
        bit deq_ok;
        fif.flush     = fl;
        fif.enq_valid = ev;
        fif.enq_pc    = pc;
        fif.enq_inst  = inst;
        fif.deq_ready = dr;
        #1;
        chk_outputs(fl);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            enq_ok = ev && (model_q.size() < FQ_DEPTH);
            deq_ok = dr && (model_q.size() > 0);
            if (deq_ok) void'(model_q.pop_front());
            if (enq_ok) model_q.push_back('{pc: pc, inst: inst});
        end
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        fif.flush = 1'b0;
        fif.enq_valid = 1'b0;
        fif.enq_pc = '0;
        fif.enq_inst = '0;
        fif.deq_ready = 1'b0;
        #12;
        chk_outputs(1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: async reset with three entries held.
        for (int i = 0; i < 3; i++) step(0, 1, 32'h500 + 32'(4*i), 32'hB0 + 32'(i), 0);
        chk("t1_count_pre", 32'(fif.count), 32'd3);
        #2 rst = 1'b1;
        model_q.delete();
        #1;
        chk_outputs(1'b0);
        chk("t1_count_rst", 32'(fif.count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Test 2: fill to full, fifth enqueue ignored, then drain in order.
        for (int i = 0; i < 5; i++) step(0, 1, 32'h1000 + 32'(4*i), 32'hC0 + 32'(i), 0);
        chk("t2_full_count", 32'(fif.count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            #1 chk("t2_drain_pc", fif.deq_pc, 32'h1000 + 32'(4*i));
            step(0, 0, 0, 0, 1);
        end
        step(0, 0, 0, 0, 1);

        // Test 3: streaming from empty, count holds at 1, pointers wrap twice.
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 32'h100 + 32'(4*i), 32'hA0 + 32'(i), 1);
            chk("t3_count", 32'(fif.count), 32'd1);
            chk("t3_inst", fif.deq_inst, 32'hA0 + 32'(i));
        end
        step(0, 0, 0, 0, 1);

        // Test 4: flush with concurrent enqueue and deq_ready.
        step(0, 1, 32'h2000, 32'hD0, 0);
        step(0, 1, 32'h2004, 32'hD1, 0);
        step(1, 1, 32'h2008, 32'hD2, 1);
        chk("t4_count_after_flush", 32'(fif.count), 32'd0);
        step(0, 0, 0, 0, 1);

        // Test 5: full, dequeue and enqueue together -> enqueue rejected, then retried.
        for (int i = 0; i < 4; i++) step(0, 1, 32'h4000 + 32'(4*i), 32'hE0 + 32'(i), 0);
        step(0, 1, 32'h4010, 32'hE4, 1);
        chk("t5_count", 32'(fif.count), 32'd3);
        step(0, 1, 32'h4010, 32'hE4, 0);
        chk("t5_retry_count", 32'(fif.count), 32'd4);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

        // Test 6: no empty bypass.
        step(0, 1, 32'h3000, 32'hF0, 1);
        chk("t6_pc_next", fif.deq_pc, 32'h3000);
        chk("t6_valid_next", {31'b0, fif.deq_valid}, 32'd1);
        step(0, 0, 0, 0, 1);

        // Random traffic including occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                 $urandom, $urandom, $urandom_range(0, 9) < 5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
